// File: rtl/bnn_act_packer_pkg.sv
// Shared constants and state encoding for the binary activation packer.
package bnn_act_packer_pkg;

    localparam int N_DEF     = 128;
    localparam int DEPTH_DEF = 8;
    localparam int BIT_CNT_W = $clog2(N_DEF) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/bnn_act_packer_if.sv
// Bit-stream input, activation-memory write port and frame status of the packer.
interface bnn_act_packer_if
    import bnn_act_packer_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int AW = 3,
    parameter int CW = BIT_CNT_W
);
    logic          start;
    logic          bit_valid;
    logic          bit_in;
    logic          bit_ready;
    logic          flush;
    logic          we;
    logic [AW-1:0] addr;
    logic [N-1:0]  dx;
    logic          done;
    logic [CW-1:0] bit_cnt;

    modport master (
        output start, bit_valid, bit_in, flush,
        input  bit_ready, we, addr, dx, done, bit_cnt
    );

    modport slave (
        input  start, bit_valid, bit_in, flush,
        output bit_ready, we, addr, dx, done, bit_cnt
    );

endinterface

// File: rtl/bnn_act_packer_assembler.sv
// Word register with LSB-first indexed bit write and fill counter.
module act_word_assembler
    import bnn_act_packer_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clear,
    input  logic                 wr_en,
    input  logic                 bit_in,
    output logic [N-1:0]         word,
    output logic [$clog2(N):0]   bit_cnt
);
    localparam int IW = $clog2(N);

    // bit_cnt reaches N only after the final write, so the low IW bits always index in range
    always_ff @(posedge clk) begin
        if (!rstn) begin
            word    <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            word    <= '0;
            bit_cnt <= '0;
        end else if (wr_en) begin
            word[bit_cnt[IW-1:0]] <= bit_in;
            bit_cnt               <= bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bnn_act_packer.sv
// Packs a serial stream of binary neuron outputs into N-bit words and writes
// one frame of DEPTH words to the activation memory.
module bnn_act_packer
    import bnn_act_packer_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    bnn_act_packer_if.slave  bus
);
    localparam int CW = $clog2(N) + 1;

    state_t        state;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic          done_q;
    logic [N-1:0]  word;
    logic [CW-1:0] cnt;

    logic          accept;
    logic          go_commit;
    logic          last_addr;
    logic          clear;

    // A flush with nothing held and nothing arriving is dropped
    always_comb begin
        accept    = (state == FILL) && bus.bit_valid;
        last_addr = (addr_q == AW'(DEPTH - 1));
        go_commit = (state == FILL) &&
                    ((accept && (cnt == CW'(N - 1))) ||
                     (bus.flush && (accept || (cnt != '0))));
        clear     = (((state == IDLE) || (state == DONE)) && bus.start) ||
                    ((state == COMMIT) && !last_addr);
    end

    act_word_assembler #(.N(N)) u_asm (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (clear),
        .wr_en   (accept),
        .bit_in  (bus.bit_in),
        .word    (word),
        .bit_cnt (cnt)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= IDLE;
            addr_q <= '0;
            we_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= FILL;
                        addr_q <= '0;
                    end
                end
                FILL: begin
                    if (go_commit) begin
                        state <= COMMIT;
                        we_q  <= 1'b1;
                    end
                end
                COMMIT: begin
                    we_q <= 1'b0;
                    if (last_addr) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        state  <= FILL;
                        addr_q <= addr_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.start) begin
                        state  <= FILL;
                        addr_q <= '0;
                        done_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.bit_ready = (state == FILL);
    assign bus.we        = we_q;
    assign bus.addr      = addr_q;
    assign bus.dx        = word;
    assign bus.done      = done_q;
    assign bus.bit_cnt   = cnt;

endmodule

// File: tb/tb_bnn_act_packer.sv
// Testbench for bnn_act_packer: vector table, multi-cycle sequences and a randomized scoreboard.
module tb_bnn_act_packer;
    import bnn_act_packer_pkg::*;

    localparam int N     = 128;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    bnn_act_packer_if #(.N(N), .AW(AW)) bus ();

    bnn_act_packer #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [N-1:0]  dx;
    } wr_t;
    wr_t got[$];

    always @(negedge clk) begin
        if (bus.we === 1'b1) got.push_back('{bus.addr, bus.dx});
    end

    typedef struct {
        logic [N-1:0] pattern;
        int           nbits;
        int           mode;     // 0: no flush, 1: flush after bits, 2: flush with last bit
        int           exp_we;
        logic [N-1:0] exp_dx;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        int n;
        n = 0;
        bus.bit_valid = 1'b1;
        bus.bit_in    = b;
        while (bus.bit_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chki("ready_timeout", 32'(n), 32'd0);
        tick();
        bus.bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [N-1:0] w);
        for (int i = 0; i < N; i++) send_bit(w[i]);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic start_frame();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    function automatic logic [N-1:0] rand_word();
        logic [N-1:0] w;
        for (int k = 0; k < N / 32; k++) w[32*k +: 32] = $urandom;
        return w;
    endfunction

    function automatic vec_t mk(input logic [31:0] pat, input int nbits, input int mode,
                                input int exp_we, input logic [31:0] exp_low);
        vec_t v;
        v.pattern       = '0;
        v.pattern[31:0] = pat;
        v.nbits         = nbits;
        v.mode          = mode;
        v.exp_we        = exp_we;
        v.exp_dx        = '0;
        v.exp_dx[31:0]  = exp_low;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] wref[8];
        logic [N-1:0] w;
        logic         q[$];
        int           exp_addr;
        int           acc;
        int           cycles;
        logic         commit_next;
        logic         exp_rdy;
        logic         v;
        logic         b;

        // Reset wins over every other input
        bus.start = 1'b1; bus.bit_valid = 1'b1; bus.bit_in = 1'b1; bus.flush = 1'b1;
        rstn = 1'b0;
        tick(); tick();
        chki("rst_we",      32'(bus.we),        32'd0);
        chki("rst_addr",    32'(bus.addr),      32'd0);
        chk ("rst_dx",      bus.dx,             '0);
        chki("rst_bit_cnt", 32'(bus.bit_cnt),   32'd0);
        chki("rst_done",    32'(bus.done),      32'd0);
        chki("rst_ready",   32'(bus.bit_ready), 32'd0);
        bus.start = 1'b0; bus.flush = 1'b0;
        rstn = 1'b1;
        tick(); tick();
        chki("idle_ready",  32'(bus.bit_ready), 32'd0);
        chki("idle_cnt",    32'(bus.bit_cnt),   32'd0);
        bus.bit_valid = 1'b0;

        // Vector table, one frame, addresses advance with each write
        vecs[0] = '{{N{1'b1}}, N, 0, 1, {N{1'b1}}};
        vecs[1] = '{{64{2'b01}}, N, 0, 1, {32{4'h5}}};
        vecs[2] = mk(32'h0000_001F, 5, 1, 1, 32'h0000_001F);
        vecs[3] = mk(32'h0000_0000, 0, 1, 0, 32'h0000_0000);
        vecs[4] = mk(32'h0000_0005, 3, 2, 1, 32'h0000_0005);
        vecs[5] = mk(32'hDEAD_BEEF, 32, 2, 1, 32'hDEAD_BEEF);
        vecs[6] = mk(32'hFFFF_FFFC, 4, 1, 1, 32'h0000_000C);

        start_frame();
        chki("start_ready", 32'(bus.bit_ready), 32'd1);
        exp_addr = 0;
        for (int i = 0; i < 7; i++) begin
            got.delete();
            for (int j = 0; j < vecs[i].nbits; j++) begin
                if (vecs[i].mode == 2 && j == vecs[i].nbits - 1) bus.flush = 1'b1;
                send_bit(vecs[i].pattern[j]);
                bus.flush = 1'b0;
            end
            if (vecs[i].mode == 1) begin
                bus.flush = 1'b1;
                tick();
                bus.flush = 1'b0;
            end
            chki($sformatf("v%0d_we_latency", i), 32'(bus.we), 32'(vecs[i].exp_we));
            repeat (3) tick();
            chki($sformatf("v%0d_we_count", i), 32'(got.size()), 32'(vecs[i].exp_we));
            if (got.size() > 0) begin
                chki($sformatf("v%0d_addr", i), 32'(got[0].addr), 32'(exp_addr));
                chk ($sformatf("v%0d_dx", i), got[0].dx, vecs[i].exp_dx);
            end
            if (vecs[i].exp_we != 0) exp_addr++;
            chki($sformatf("v%0d_addr_after", i), 32'(bus.addr), 32'(exp_addr));
            chki($sformatf("v%0d_cnt_after", i), 32'(bus.bit_cnt), 32'd0);
            chki($sformatf("v%0d_ready_after", i), 32'(bus.bit_ready), 32'd1);
        end

        // Full frame of eight words, then DONE holds without wrapping
        do_reset();
        start_frame();
        got.delete();
        for (int k = 0; k < DEPTH; k++) begin
            wref[k] = rand_word();
            send_word(wref[k]);
            if (k < DEPTH - 1) chki($sformatf("frame_done_early%0d", k), 32'(bus.done), 32'd0);
        end
        tick();
        chki("frame_done",  32'(bus.done),      32'd1);
        chki("frame_ready", 32'(bus.bit_ready), 32'd0);
        bus.bit_valid = 1'b1; bus.flush = 1'b1;
        repeat (5) tick();
        bus.bit_valid = 1'b0; bus.flush = 1'b0;
        chki("frame_done_hold", 32'(bus.done), 32'd1);
        chki("frame_addr_hold", 32'(bus.addr), 32'(DEPTH - 1));
        chki("frame_writes",    32'(got.size()), 32'(DEPTH));
        for (int k = 0; k < DEPTH && k < got.size(); k++) begin
            chki($sformatf("frame_addr%0d", k), 32'(got[k].addr), 32'(k));
            chk ($sformatf("frame_dx%0d", k), got[k].dx, wref[k]);
        end
        start_frame();
        chki("restart_done",  32'(bus.done),      32'd0);
        chki("restart_ready", 32'(bus.bit_ready), 32'd1);
        chki("restart_addr",  32'(bus.addr),      32'd0);

        // Random valid with stray start pulses against a stream scoreboard
        do_reset();
        start_frame();
        got.delete();
        q.delete();
        acc = 0; cycles = 0; commit_next = 1'b0;
        while (acc < 3 * N + 40 && cycles < 5000) begin
            v = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            bus.bit_valid = v;
            bus.bit_in    = b;
            bus.start     = ($urandom_range(0, 7) == 0);
            exp_rdy       = !commit_next;
            chki("rand_ready", 32'(bus.bit_ready), 32'(exp_rdy));
            commit_next = 1'b0;
            if (v && exp_rdy) begin
                q.push_back(b);
                acc++;
                if (acc % N == 0) commit_next = 1'b1;
            end
            tick();
            cycles++;
        end
        if (cycles >= 5000) chki("rand_timeout", 32'(acc), 32'(3 * N + 40));
        bus.bit_valid = 1'b0; bus.start = 1'b0;
        chki("rand_partial_cnt", 32'(bus.bit_cnt), 32'd40);
        for (int k = 0; k < 4; k++) begin
            bus.start = 1'b1; tick(); bus.start = 1'b0; tick();
        end
        chki("rand_idle_cnt", 32'(bus.bit_cnt), 32'd40);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        repeat (3) tick();
        chki("rand_writes", 32'(got.size()), 32'd4);
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            w = '0;
            for (int j = 0; j < N && k * N + j < q.size(); j++) w[j] = q[k * N + j];
            chki($sformatf("rand_addr%0d", k), 32'(got[k].addr), 32'(k));
            chk ($sformatf("rand_dx%0d", k), got[k].dx, w);
        end

        // Reset part-way through word 3 discards it; next frame restarts at 0
        do_reset();
        start_frame();
        got.delete();
        for (int k = 0; k < 3; k++) send_word(rand_word());
        for (int j = 0; j < 60; j++) send_bit(1'($urandom_range(0, 1)));
        chki("mid_cnt",  32'(bus.bit_cnt), 32'd60);
        chki("mid_addr", 32'(bus.addr),    32'd3);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chki("mid_rst_ready", 32'(bus.bit_ready), 32'd0);
        chki("mid_rst_addr",  32'(bus.addr),      32'd0);
        chki("mid_rst_cnt",   32'(bus.bit_cnt),   32'd0);
        chk ("mid_rst_dx",    bus.dx,             '0);
        repeat (3) tick();
        chki("mid_rst_writes", 32'(got.size()), 32'd3);
        got.delete();
        start_frame();
        w = rand_word();
        send_word(w);
        repeat (2) tick();
        chki("post_rst_writes", 32'(got.size()), 32'd1);
        if (got.size() > 0) begin
            chki("post_rst_addr", 32'(got[0].addr), 32'd0);
            chk ("post_rst_dx",   got[0].dx,        w);
        end

        // Reset landing on the COMMIT cycle suppresses any later write
        send_word(rand_word());
        chki("commit_we", 32'(bus.we), 32'd1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        got.delete();
        chki("commit_rst_we",    32'(bus.we),        32'd0);
        chki("commit_rst_ready", 32'(bus.bit_ready), 32'd0);
        repeat (4) tick();
        chki("commit_rst_writes", 32'(got.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
